// File: rtl/bp_be_pkg.sv
// Shared types for the BE issue queue.
//   bp_be_iq_state_e : sequencing state of the issue-queue pointer controller.
//                      RUN     - normal enqueue/issue traffic.
//                      RECOVER - one-cycle bubble after a clear or rollback,
//                                giving the regfile preread time to refetch.
package bp_be_pkg;

  typedef enum logic {
    e_iq_run     = 1'b0,
    e_iq_recover = 1'b1
  } bp_be_iq_state_e;

endpackage

// File: rtl/bp_be_issue_queue_ctrl.sv
// Pointer/sequencing controller for the BE issue queue storage.
// Keeps three circular pointers (write/enq, read/speculative issue,
// commit/retired), each one bit wider than the storage index so that full and
// empty can be told apart by the wrap bit.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   enq_v_i / ready_o    FE enqueue handshake; waddr_o is the write index
//   v_o / yumi_i         ISD issue handshake; raddr_o is the read index
//   preissue_addr_o      read index for the next cycle (regfile preread)
//   deq_v_i              commit oldest issued entry
//   roll_v_i             rewind read pointer to the commit pointer
//   clr_v_i              drop all unissued entries
//   empty_o              nothing in flight (write ptr == commit ptr)
module bp_be_issue_queue_ctrl
  import bp_be_pkg::*;
#(
  parameter  int els_p        = 16,
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enq_v_i,
  output logic                    ready_o,
  output logic [ptr_width_lp-1:0] waddr_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [ptr_width_lp-1:0] raddr_o,
  output logic [ptr_width_lp-1:0] preissue_addr_o,
  input  logic                    deq_v_i,
  input  logic                    roll_v_i,
  input  logic                    clr_v_i,
  output logic                    empty_o
);

  localparam int pw_lp = ptr_width_lp + 1;

  logic [pw_lp-1:0] wptr_q, wptr_d;
  logic [pw_lp-1:0] rptr_q, rptr_d;
  logic [pw_lp-1:0] cptr_q, cptr_d;
  bp_be_iq_state_e  state_q, state_d;

  logic run, full;
  logic enq_acc, yumi_acc, deq_acc;

  assign run  = (state_q == e_iq_run);
  // Same slot but different lap: the writer is a whole queue ahead of commit.
  assign full = (wptr_q[ptr_width_lp-1:0] == cptr_q[ptr_width_lp-1:0])
              & (wptr_q[ptr_width_lp] != cptr_q[ptr_width_lp]);

  assign ready_o = ~full & run;
  assign v_o     = (rptr_q != wptr_q) & run;
  assign empty_o = (wptr_q == cptr_q);
  assign waddr_o = wptr_q[ptr_width_lp-1:0];
  assign raddr_o = rptr_q[ptr_width_lp-1:0];

  assign enq_acc  = enq_v_i & ready_o;
  assign yumi_acc = yumi_i & v_o;
  // A commit with nothing in flight is a protocol error; drop it rather than
  // let the commit pointer overtake the write pointer.
  assign deq_acc  = deq_v_i & ~empty_o;

  always_comb begin
    cptr_d  = cptr_q + pw_lp'(deq_acc);
    rptr_d  = rptr_q + pw_lp'(yumi_acc);
    wptr_d  = wptr_q + pw_lp'(enq_acc);
    state_d = e_iq_run;

    if (clr_v_i) begin
      // Clear discards unissued work; with a simultaneous rollback the read
      // pointer rewinds first and the write pointer follows it.
      rptr_d = roll_v_i ? cptr_d : rptr_q;
      wptr_d = rptr_d;
    end else if (roll_v_i) begin
      rptr_d = cptr_d;
    end

    if (run && (clr_v_i || roll_v_i)) begin
      state_d = e_iq_recover;
    end
  end

  // Next-cycle read index so the regfile preread lands one cycle early.
  assign preissue_addr_o = rptr_d[ptr_width_lp-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cptr_q  <= '0;
      state_q <= e_iq_run;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cptr_q  <= cptr_d;
      state_q <= state_d;
    end
  end

  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    yumi_i |-> v_o);
  a_deq_needs_work : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                      deq_v_i |-> !empty_o);

endmodule

// File: tb/tb_bp_be_issue_queue_ctrl.sv
module tb_bp_be_issue_queue_ctrl;

  localparam int ELS = 16;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       enq_v_i, yumi_i, deq_v_i, roll_v_i, clr_v_i;
  logic       ready_o, v_o, empty_o;
  logic [3:0] waddr_o, raddr_o, preissue_addr_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: unbounded counts of entries ever written / issued / committed.
  // Storage indices are those counts modulo the depth.
  int m_c, m_r, m_w;
  bit m_rec;

  always #5 clk_i = ~clk_i;

  bp_be_issue_queue_ctrl #(.els_p(ELS)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .enq_v_i         (enq_v_i),
    .ready_o         (ready_o),
    .waddr_o         (waddr_o),
    .v_o             (v_o),
    .yumi_i          (yumi_i),
    .raddr_o         (raddr_o),
    .preissue_addr_o (preissue_addr_o),
    .deq_v_i         (deq_v_i),
    .roll_v_i        (roll_v_i),
    .clr_v_i         (clr_v_i),
    .empty_o         (empty_o)
  );

  function automatic bit m_v();
    return (m_r < m_w) && !m_rec;
  endfunction

  function automatic bit m_ready();
    return ((m_w - m_c) < ELS) && !m_rec;
  endfunction

  function automatic bit m_empty();
    return m_w == m_c;
  endfunction

  function automatic void m_next(input bit e, input bit y, input bit d,
                                 input bit ro, input bit cl,
                                 output int c2, output int r2, output int w2,
                                 output bit rec2);
    int ea, ya;
    ea = (e && m_ready()) ? 1 : 0;
    ya = (y && m_v()) ? 1 : 0;
    c2 = m_c + ((d && !m_empty()) ? 1 : 0);
    if (cl) begin
      r2 = ro ? c2 : m_r;
      w2 = r2;
    end else if (ro) begin
      r2 = c2;
      w2 = m_w + ea;
    end else begin
      r2 = m_r + ya;
      w2 = m_w + ea;
    end
    rec2 = !m_rec && (cl || ro);
  endfunction

  task automatic m_reset();
    m_c = 0; m_r = 0; m_w = 0; m_rec = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin : cmp
    int c2, r2, w2;
    bit rc;
    if (chk_en) begin
      m_next(enq_v_i, yumi_i, deq_v_i, roll_v_i, clr_v_i, c2, r2, w2, rc);
      chk("ready_o",  int'(ready_o),  int'(m_ready()));
      chk("v_o",      int'(v_o),      int'(m_v()));
      chk("empty_o",  int'(empty_o),  int'(m_empty()));
      chk("waddr_o",  int'(waddr_o),  m_w % ELS);
      chk("raddr_o",  int'(raddr_o),  m_r % ELS);
      chk("preissue", int'(preissue_addr_o), r2 % ELS);
    end
  end

  task automatic drive(input bit e, input bit y, input bit d, input bit ro, input bit cl);
    enq_v_i = e; yumi_i = y; deq_v_i = d; roll_v_i = ro; clr_v_i = cl;
  endtask

  // Advance one clock; model sees the same inputs the DUT sampled.
  task automatic clk_step();
    int c2, r2, w2;
    bit rc;
    @(posedge clk_i);
    m_next(enq_v_i, yumi_i, deq_v_i, roll_v_i, clr_v_i, c2, r2, w2, rc);
    m_c = c2; m_r = r2; m_w = w2; m_rec = rc;
    #1;
  endtask

  task automatic steps(input int n, input bit e, input bit y, input bit d);
    for (int i = 0; i < n; i++) begin
      drive(e, y, d, 1'b0, 1'b0);
      clk_step();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    drive(0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    m_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic rand_cycles(input int n);
    bit e, y, d, ro, cl;
    for (int i = 0; i < n; i++) begin
      e  = ($urandom_range(3) != 0);
      y  = m_v() && ($urandom_range(3) != 0);
      d  = (m_c < m_r) && ($urandom_range(2) != 0);
      ro = ($urandom_range(24) == 0);
      cl = ($urandom_range(24) == 0);
      drive(e, y, d, ro, cl);
      clk_step();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst ready_o", int'(ready_o), 1);
    chk("rst v_o",     int'(v_o),     0);
    chk("rst empty_o", int'(empty_o), 1);
    chk("rst waddr_o", int'(waddr_o), 0);
    chk("rst raddr_o", int'(raddr_o), 0);

    // 1: fill the queue
    steps(15, 1, 0, 0);
    chk("t1 waddr15", int'(waddr_o), 15);
    steps(1, 1, 0, 0);
    chk("t1 ready_o", int'(ready_o), 0);
    chk("t1 waddr0",  int'(waddr_o), 0);
    chk("t1 empty_o", int'(empty_o), 0);
    chk("t1 v_o",     int'(v_o),     1);
    steps(2, 1, 0, 0);
    chk("t1 full hold waddr", int'(waddr_o), 0);

    // 2: enq 3, issue 3, commit 3
    do_reset();
    steps(3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2 v_o before yumi", int'(v_o), 1);
      steps(1, 0, 1, 0);
    end
    chk("t2 v_o drained", int'(v_o), 0);
    steps(3, 0, 0, 1);
    chk("t2 empty_o", int'(empty_o), 1);
    chk("t2 waddr",   int'(waddr_o), 3);
    chk("t2 raddr",   int'(raddr_o), 3);
    chk("t2 preissue", int'(preissue_addr_o), 3);

    // 3: rollback to commit point
    do_reset();
    steps(5, 1, 0, 0);
    steps(4, 0, 1, 0);
    steps(1, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    clk_step();
    drive(0, 0, 0, 0, 0);
    chk("t3 recover v_o",     int'(v_o),     0);
    chk("t3 recover ready_o", int'(ready_o), 0);
    clk_step();
    chk("t3 raddr", int'(raddr_o), 1);
    chk("t3 v_o",   int'(v_o),     1);

    // 4: clear drops unissued work and a concurrent enqueue
    do_reset();
    steps(6, 1, 0, 0);
    steps(2, 0, 1, 0);
    drive(1, 0, 0, 0, 1);
    clk_step();
    drive(0, 0, 0, 0, 0);
    chk("t4 recover v_o", int'(v_o), 0);
    clk_step();
    chk("t4 v_o",   int'(v_o),     0);
    chk("t4 waddr", int'(waddr_o), 2);

    // 5: commit and rollback in the same cycle
    do_reset();
    steps(8, 1, 0, 0);
    steps(8, 0, 1, 0);
    steps(7, 0, 0, 1);
    drive(0, 0, 1, 1, 0);
    #1;
    chk("t5 preissue", int'(preissue_addr_o), 8);
    clk_step();
    drive(0, 0, 0, 0, 0);
    chk("t5 raddr", int'(raddr_o), 8);

    // 6: random traffic across several wraps, then async reset mid-cycle
    do_reset();
    rand_cycles(400);
    #1;
    chk_en = 1'b0;
    reset_n_i = 1'b0;
    m_reset();
    #1;
    chk("t6 async ready_o",  int'(ready_o),  1);
    chk("t6 async v_o",      int'(v_o),      0);
    chk("t6 async empty_o",  int'(empty_o),  1);
    chk("t6 async waddr",    int'(waddr_o),  0);
    chk("t6 async raddr",    int'(raddr_o),  0);
    chk("t6 async preissue", int'(preissue_addr_o), 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    chk_en = 1'b1;
    rand_cycles(100);

    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
